// File: rtl/aespim_gf128_acc_if.sv
`default_nettype none
// aespim_gf128_acc_if: beat input, result handshake and status bundle for the GF(2^128) accumulator.
interface aespim_gf128_acc_if;
  logic         start_i;
  logic         busy_o;
  logic         in_valid_i;
  logic         in_ready_o;
  logic [2:0]   shift_idx_i;
  logic [31:0]  c0_i;
  logic [31:0]  c1_i;
  logic [7:0]   c3_i;
  logic         res_valid_o;
  logic         res_ready_i;
  logic [127:0] res_o;
  logic         err_o;

  modport master (
    output start_i, in_valid_i, shift_idx_i, c0_i, c1_i, c3_i, res_ready_i,
    input  busy_o, in_ready_o, res_valid_o, res_o, err_o
  );

  modport slave (
    input  start_i, in_valid_i, shift_idx_i, c0_i, c1_i, c3_i, res_ready_i,
    output busy_o, in_ready_o, res_valid_o, res_o, err_o
  );
endinterface
`default_nettype wire

// File: rtl/aespim_gf128_acc.sv
`default_nettype none
// aespim_gf128_acc: folds NUM_BEATS reduced partial-product beats into a 128-bit GF(2^128) product.
// Optional macro AESPIM_ACC_IDXCHK_EN flags an accepted beat with shift index 7 on err_o.
module aespim_gf128_acc #(
  parameter int NUM_BEATS = 16
) (
  input  wire                  clk_i,
  input  wire                  rst_ni,
  aespim_gf128_acc_if.slave    bus
);

  localparam int                CNT_W    = $clog2(NUM_BEATS + 1);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(NUM_BEATS - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ACCUM = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic [CNT_W-1:0]     r_cnt;
  logic [CNT_W-1:0]     w_cnt_nxt;
  logic [3:0][31:0]     r_acc;
  logic [3:0][31:0]     w_acc_nxt;
  logic [3:0][31:0]     w_delta;
  logic                 w_accept;
  logic                 w_start_clr;

  assign w_accept    = bus.in_valid_i && (r_state == S_ACCUM);
  assign w_start_clr = bus.start_i && (r_state == S_IDLE);

  // Word positions wrap mod 4; c3 only lands when the beat straddles the fold (k=3..5).
  always_comb begin
    w_delta = '0;
    case (bus.shift_idx_i)
      3'd0: begin w_delta[0] = bus.c0_i; w_delta[1] = bus.c1_i; end
      3'd1: begin w_delta[1] = bus.c0_i; w_delta[2] = bus.c1_i; end
      3'd2: begin w_delta[2] = bus.c0_i; w_delta[3] = bus.c1_i; end
      3'd3: begin
        w_delta[3] = bus.c0_i;
        w_delta[0] = bus.c1_i;
        w_delta[1] = {24'd0, bus.c3_i};
      end
      3'd4: begin
        w_delta[0] = bus.c0_i;
        w_delta[1] = bus.c1_i;
        w_delta[2] = {24'd0, bus.c3_i};
      end
      3'd5: begin
        w_delta[1] = bus.c0_i;
        w_delta[2] = bus.c1_i;
        w_delta[3] = {24'd0, bus.c3_i};
      end
      3'd6: begin w_delta[2] = bus.c0_i; w_delta[3] = bus.c1_i; end
      default: w_delta = '0;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_acc_nxt   = r_acc;
    case (r_state)
      S_IDLE: begin
        if (w_start_clr) begin
          w_state_nxt = S_ACCUM;
          w_cnt_nxt   = '0;
          w_acc_nxt   = '0;
        end
      end
      S_ACCUM: begin
        if (w_accept) begin
          w_acc_nxt = r_acc ^ w_delta;
          w_cnt_nxt = r_cnt + CNT_W'(1);
          if (r_cnt == LAST_CNT) begin
            w_state_nxt = S_DONE;
          end
        end
      end
      S_DONE: begin
        if (bus.res_ready_i) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_acc   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_acc   <= w_acc_nxt;
    end
  end

`ifdef AESPIM_ACC_IDXCHK_EN
  logic r_err;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_err <= 1'b0;
    end else if (w_start_clr) begin
      r_err <= 1'b0;
    end else if (w_accept && (bus.shift_idx_i == 3'd7)) begin
      r_err <= 1'b1;
    end
  end

  assign bus.err_o = r_err;
`else
  assign bus.err_o = 1'b0;
`endif

  assign bus.busy_o      = (r_state != S_IDLE);
  assign bus.in_ready_o  = (r_state == S_ACCUM);
  assign bus.res_valid_o = (r_state == S_DONE);
  assign bus.res_o       = r_acc;

endmodule
`default_nettype wire

// File: tb/tb_aespim_gf128_acc.sv
`default_nettype none
// tb_aespim_gf128_acc: directed and randomized checks of the GF(2^128) accumulator against a word-fold model.
module tb_aespim_gf128_acc;
  localparam int NB = 16;
`ifdef AESPIM_ACC_IDXCHK_EN
  localparam bit IDXCHK = 1'b1;
`else
  localparam bit IDXCHK = 1'b0;
`endif

  typedef struct packed {
    logic [2:0]  k;
    logic [31:0] c0;
    logic [31:0] c1;
    logic [7:0]  c3;
  } beat_t;

  logic  clk_i  = 1'b0;
  logic  rst_ni = 1'b0;
  int    n_checks = 0;
  int    n_fail   = 0;
  beat_t q[$];

  aespim_gf128_acc_if bus ();

  aespim_gf128_acc #(.NUM_BEATS(NB)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  // Beat k contributes c0 at word k, c1 at word k+1 (positions taken mod 4);
  // c3 only exists for beats that cross the 128-bit fold.
  function automatic logic [127:0] model();
    logic [31:0] w [4];
    for (int i = 0; i < 4; i++) w[i] = 32'd0;
    foreach (q[i]) begin
      int k;
      k = int'(q[i].k);
      if (k <= 6) begin
        w[k % 4]       ^= q[i].c0;
        w[(k + 1) % 4] ^= q[i].c1;
        if (k >= 3 && k <= 5) w[(k + 2) % 4][7:0] ^= q[i].c3;
      end
    end
    return {w[3], w[2], w[1], w[0]};
  endfunction

  function automatic bit any7();
    bit r;
    r = 1'b0;
    foreach (q[i]) if (q[i].k == 3'd7) r = 1'b1;
    return r;
  endfunction

  task automatic gen_rand(input bit allow7);
    q.delete();
    for (int i = 0; i < NB; i++) begin
      beat_t b;
      b.k  = allow7 ? 3'($urandom_range(0, 7)) : 3'($urandom_range(0, 6));
      b.c0 = $urandom;
      b.c1 = $urandom;
      b.c3 = 8'($urandom);
      q.push_back(b);
    end
  endtask

  task automatic start_txn();
    bus.start_i = 1'b1;
    tick();
    bus.start_i    = 1'b0;
    bus.in_valid_i = 1'b0;
    chk("start_status", {bus.busy_o, bus.in_ready_o, bus.res_valid_o, bus.err_o}, 4'b1100);
    chk("start_clear", bus.res_o, 128'd0);
  endtask

  task automatic send_beats(input int n, input bit toggle, input int start_at);
    for (int i = 0; i < n; i++) begin
      int waitc;
      if (toggle) begin
        bus.in_valid_i  = 1'b0;
        bus.shift_idx_i = 3'($urandom);
        bus.c0_i        = $urandom;
        tick();
      end
      bus.shift_idx_i = q[i].k;
      bus.c0_i        = q[i].c0;
      bus.c1_i        = q[i].c1;
      bus.c3_i        = q[i].c3;
      bus.in_valid_i  = 1'b1;
      bus.start_i     = (i == start_at);
      waitc = 0;
      while (bus.in_ready_o !== 1'b1 && waitc < 4) begin
        tick();
        waitc++;
      end
      chk("beat_ready", bus.in_ready_o, 1'b1);
      if (bus.in_ready_o !== 1'b1) begin
        bus.in_valid_i = 1'b0;
        bus.start_i    = 1'b0;
        return;
      end
      if (i == NB - 1) chk("no_early_valid", bus.res_valid_o, 1'b0);
      tick();
    end
    bus.in_valid_i = 1'b0;
    bus.start_i    = 1'b0;
  endtask

  task automatic finish_txn(input logic [127:0] exp, input bit exp_err, input int hold, input bit start_w_ready);
    // A surplus beat offered after the last one must not be taken.
    bus.in_valid_i  = 1'b1;
    bus.shift_idx_i = 3'd0;
    bus.c0_i        = $urandom | 32'h1;
    bus.res_ready_i = 1'b0;
    chk("res_valid_next", bus.res_valid_o, 1'b1);
    chk("ready_in_done", bus.in_ready_o, 1'b0);
    chk("res_o", bus.res_o, exp);
    chk("err_done", bus.err_o, exp_err);
    for (int i = 0; i < hold; i++) begin
      tick();
      chk("hold_valid", bus.res_valid_o, 1'b1);
      chk("hold_res", bus.res_o, exp);
    end
    bus.in_valid_i  = 1'b0;
    bus.res_ready_i = 1'b1;
    bus.start_i     = start_w_ready;
    tick();
    bus.res_ready_i = 1'b0;
    bus.start_i     = 1'b0;
    chk("idle_after_hs", {bus.busy_o, bus.res_valid_o, bus.in_ready_o, bus.err_o}, {3'b000, exp_err});
    tick();
    chk("still_idle", bus.busy_o, 1'b0);
  endtask

  initial begin
    logic [127:0] exp;
    bus.start_i     = 1'b0;
    bus.in_valid_i  = 1'b0;
    bus.shift_idx_i = 3'd0;
    bus.c0_i        = 32'd0;
    bus.c1_i        = 32'd0;
    bus.c3_i        = 8'd0;
    bus.res_ready_i = 1'b0;

    // Reset state
    #12;
    chk("rst_status", {bus.busy_o, bus.in_ready_o, bus.res_valid_o, bus.err_o}, 4'b0000);
    chk("rst_res", bus.res_o, 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();

    // Even number of identical beats cancels
    q.delete();
    for (int i = 0; i < NB; i++) q.push_back('{k: 3'd0, c0: 32'h1, c1: 32'h0, c3: 8'h0});
    start_txn();
    send_beats(NB, 1'b0, -1);
    finish_txn(128'd0, 1'b0, 2, 1'b0);

    // Single straddling beat k=3 then zeros
    q.delete();
    q.push_back('{k: 3'd3, c0: 32'hA5A5A5A5, c1: 32'h00000001, c3: 8'h3C});
    for (int i = 1; i < NB; i++) q.push_back('{k: 3'd0, c0: 32'h0, c1: 32'h0, c3: 8'h0});
    start_txn();
    send_beats(NB, 1'b0, -1);
    finish_txn(128'hA5A5A5A5_00000000_0000003C_00000001, 1'b0, 1, 1'b0);

    // in_valid held in IDLE, toggled valid, start pulse mid-run, back-pressure, start with ready
    gen_rand(1'b0);
    bus.in_valid_i  = 1'b1;
    bus.shift_idx_i = 3'd1;
    bus.c0_i        = 32'hDEADBEEF;
    bus.c1_i        = 32'hCAFEF00D;
    tick();
    tick();
    chk("idle_no_accept", {bus.busy_o, bus.in_ready_o}, 2'b00);
    start_txn();
    send_beats(NB, 1'b1, 4);
    finish_txn(model(), 1'b0, 5, 1'b1);

    // Asynchronous reset mid-accumulation
    gen_rand(1'b0);
    start_txn();
    send_beats(7, 1'b0, -1);
    #2;
    rst_ni = 1'b0;
    #1;
    chk("async_rst_status", {bus.busy_o, bus.in_ready_o, bus.res_valid_o, bus.err_o}, 4'b0000);
    chk("async_rst_res", bus.res_o, 128'd0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    tick();
    chk("post_rst_idle", {bus.busy_o, bus.res_valid_o}, 2'b00);
    gen_rand(1'b0);
    start_txn();
    send_beats(NB, 1'b0, -1);
    finish_txn(model(), 1'b0, 0, 1'b0);

    // Illegal index 7 leaves accumulator unchanged
    q.delete();
    q.push_back('{k: 3'd7, c0: 32'hFFFFFFFF, c1: 32'h12345678, c3: 8'hFF});
    for (int i = 1; i < NB; i++) q.push_back('{k: 3'd2, c0: 32'h0, c1: 32'h0, c3: 8'h0});
    start_txn();
    send_beats(NB, 1'b0, -1);
    finish_txn(128'd0, IDXCHK, 1, 1'b0);

    // Randomized runs, index 7 allowed
    for (int t = 0; t < 4; t++) begin
      gen_rand(1'b1);
      exp = model();
      start_txn();
      send_beats(NB, t[0], -1);
      finish_txn(exp, IDXCHK && any7(), t, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
`default_nettype wire
